// File: rtl/viterbi_ctrl_if.sv
// rtl/viterbi_ctrl_if.sv - symbol-in and decoded-bit-out handshake bundle for viterbi_ctrl
interface viterbi_ctrl_if;
  logic       sym_valid_i;
  logic       sym_ready_o;
  logic [1:0] sym_i;
  logic       frame_last_i;
  logic       dec_valid_o;
  logic       dec_ready_i;
  logic       dec_drain_o;

  modport master (
    output sym_valid_i, sym_i, frame_last_i, dec_ready_i,
    input  sym_ready_o, dec_valid_o, dec_drain_o
  );

  modport slave (
    input  sym_valid_i, sym_i, frame_last_i, dec_ready_i,
    output sym_ready_o, dec_valid_o, dec_drain_o
  );
endinterface

// File: rtl/viterbi_ctrl.sv
// rtl/viterbi_ctrl.sv - sequencing FSM for a K=7 Viterbi ACS/register-exchange datapath
module viterbi_ctrl #(
  parameter int TBLEN       = 60,
  parameter int PM_MAX_BITS = 11,
  parameter int NORM_THRESH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  viterbi_ctrl_if.slave        bus,
  output logic                 acs_init_o,
  output logic                 acs_en_o,
  output logic [1:0]           acs_sym_o,
  input  logic [PM_MAX_BITS:0] pm_min_i,
  output logic                 norm_en_o,
  output logic [PM_MAX_BITS:0] norm_val_o,
  output logic                 frame_done_o,
  output logic                 busy_o
);
  localparam int PM_W = PM_MAX_BITS + 1;
  localparam logic [6:0]      DEPTH_MAX = 7'(TBLEN + 1);
  localparam logic [6:0]      TB_DEPTH  = 7'(TBLEN);
  localparam logic [PM_W-1:0] THRESH    = PM_W'(NORM_THRESH);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_STEP, S_ACS, S_CHK, S_DRAIN} state_t;

  state_t     state_q, state_d;
  logic [6:0] depth_q, depth_d;
  logic [6:0] remain_q, remain_d;
  logic       last_q, last_d;
  logic [1:0] acs_sym_q, acs_sym_d;
  logic       dec_valid_q, dec_valid_d;
  logic       dec_drain_q, dec_drain_d;
  logic       frame_done_q, frame_done_d;
  logic       sym_ready;
  logic       sym_hs;
  logic       dec_hs;
  logic       norm_hit;

  // A held decoded bit blocks new symbols so the register exchange cannot overrun the sink.
  assign sym_ready = (state_q == S_STEP) && !(dec_valid_q && !bus.dec_ready_i);
  assign sym_hs    = sym_ready && bus.sym_valid_i;
  assign dec_hs    = dec_valid_q && bus.dec_ready_i;
  assign norm_hit  = (state_q == S_CHK) && (pm_min_i >= THRESH);

  assign bus.sym_ready_o = sym_ready;
  assign bus.dec_valid_o = dec_valid_q;
  assign bus.dec_drain_o = dec_drain_q;
  assign acs_init_o      = (state_q == S_INIT);
  assign acs_en_o        = (state_q == S_ACS);
  assign acs_sym_o       = acs_sym_q;
  assign norm_en_o       = norm_hit;
  assign norm_val_o      = norm_hit ? pm_min_i : '0;
  assign frame_done_o    = frame_done_q;
  assign busy_o          = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    remain_d     = remain_q;
    last_d       = last_q;
    acs_sym_d    = acs_sym_q;
    dec_valid_d  = dec_valid_q && !bus.dec_ready_i;
    dec_drain_d  = dec_drain_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.sym_valid_i) state_d = S_INIT;
      end
      S_INIT: begin
        depth_d = '0;
        last_d  = 1'b0;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (sym_hs) begin
          acs_sym_d = bus.sym_i;
          last_d    = bus.frame_last_i;
          state_d   = S_ACS;
        end
      end
      S_ACS: begin
        if (depth_q != DEPTH_MAX) depth_d = depth_q + 7'd1;
        state_d = S_CHK;
      end
      S_CHK: begin
        if (depth_q == DEPTH_MAX) dec_valid_d = 1'b1;
        if (last_q) begin
          remain_d = (depth_q > TB_DEPTH) ? TB_DEPTH : depth_q;
          state_d  = S_DRAIN;
        end else begin
          state_d = S_STEP;
        end
      end
      S_DRAIN: begin
        // Tail phase starts only once any in-flight normal bit has left.
        if (!dec_drain_q) begin
          if (!dec_valid_q || bus.dec_ready_i) begin
            dec_valid_d = 1'b1;
            dec_drain_d = 1'b1;
          end
        end else if (dec_hs) begin
          if (remain_q == 7'd1) begin
            remain_d     = '0;
            dec_valid_d  = 1'b0;
            dec_drain_d  = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            remain_d    = remain_q - 7'd1;
            dec_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      depth_q      <= '0;
      remain_q     <= '0;
      last_q       <= 1'b0;
      acs_sym_q    <= '0;
      dec_valid_q  <= 1'b0;
      dec_drain_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      remain_q     <= remain_d;
      last_q       <= last_d;
      acs_sym_q    <= acs_sym_d;
      dec_valid_q  <= dec_valid_d;
      dec_drain_q  <= dec_drain_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb/tb_viterbi_ctrl.sv - scoreboard bench for viterbi_ctrl with directed frames
module tb_viterbi_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        acs_init_o, acs_en_o, norm_en_o, frame_done_o, busy_o;
  logic [1:0]  acs_sym_o;
  logic [11:0] pm_min_i, norm_val_o;

  always #5 clk = ~clk;

  viterbi_ctrl_if bus();

  viterbi_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .acs_init_o   (acs_init_o),
    .acs_en_o     (acs_en_o),
    .acs_sym_o    (acs_sym_o),
    .pm_min_i     (pm_min_i),
    .norm_en_o    (norm_en_o),
    .norm_val_o   (norm_val_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [1:0] sym;
    int         due;
  } acs_exp_t;

  acs_exp_t    q_acs[$];
  logic        q_dec[$];
  logic [11:0] q_norm[$];
  int          q_done[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_init = 0;
  logic [11:0] pm_tab[0:127];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      if (acs_init_o) n_init++;
      if (acs_en_o) begin
        check("acs_en expected", q_acs.size() > 0, 1);
        if (q_acs.size() > 0) begin
          acs_exp_t e;
          e = q_acs.pop_front();
          check("acs_sym", acs_sym_o, e.sym);
          check("acs_cycle", cyc, e.due);
        end
      end
      if (norm_en_o) begin
        check("norm_en expected", q_norm.size() > 0, 1);
        if (q_norm.size() > 0) check("norm_val", norm_val_o, q_norm.pop_front());
      end else if (norm_val_o !== 12'd0) begin
        check("norm_val idle", norm_val_o, 0);
      end
      if (bus.dec_valid_o && bus.dec_ready_i) begin
        check("dec bit expected", q_dec.size() > 0, 1);
        if (q_dec.size() > 0) check("dec_drain", bus.dec_drain_o, q_dec.pop_front());
      end
      if (frame_done_o) begin
        check("frame_done expected", q_done.size() > 0, 1);
        if (q_done.size() > 0) begin
          void'(q_done.pop_front());
          check("bits left at done", q_dec.size(), 0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " sym_ready"},  bus.sym_ready_o, 0);
    check({tag, " acs_init"},   acs_init_o, 0);
    check({tag, " acs_en"},     acs_en_o, 0);
    check({tag, " acs_sym"},    acs_sym_o, 0);
    check({tag, " norm_en"},    norm_en_o, 0);
    check({tag, " norm_val"},   norm_val_o, 0);
    check({tag, " dec_valid"},  bus.dec_valid_o, 0);
    check({tag, " dec_drain"},  bus.dec_drain_o, 0);
    check({tag, " frame_done"}, frame_done_o, 0);
    check({tag, " busy"},       busy_o, 0);
  endtask

  task automatic send_frame(input int n, input int stall_at, input int rst_at);
    int prev = -1;
    int init0 = n_init;
    int t;
    for (int k = 1; k <= n; k++) begin
      bus.sym_valid_i  = 1'b1;
      bus.sym_i        = 2'(k * 3 + n);
      bus.frame_last_i = (k == n);
      if (stall_at > 0 && k - 1 == stall_at) begin
        bus.dec_ready_i = 1'b0;
        repeat (10) @(negedge clk);
        check("stall sym_ready", bus.sym_ready_o, 0);
        check("stall dec_valid held", bus.dec_valid_o, 1);
        @(posedge clk);
        #1 bus.dec_ready_i = 1'b1;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.sym_ready_o && t < 100);
      if (!bus.sym_ready_o) begin
        check("sym_ready timeout", bus.sym_ready_o, 1);
        bus.sym_valid_i = 1'b0;
        return;
      end
      if (prev >= 0 && k - 1 != stall_at) check("accept spacing", cyc - prev, 3);
      prev = cyc;
      q_acs.push_back('{sym: bus.sym_i, due: cyc + 1});
      if (pm_tab[k] >= 12'd1024) q_norm.push_back(pm_tab[k]);
      if (k >= 61) q_dec.push_back(1'b0);
      if (k == n) begin
        repeat ((n < 60) ? n : 60) q_dec.push_back(1'b1);
        q_done.push_back(n);
      end
      @(posedge clk);
      #1;
      bus.sym_valid_i = 1'b0;
      pm_min_i = pm_tab[k];
      if (k == rst_at) begin
        check("acs_en before rst", acs_en_o, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async rst");
        q_acs.delete();
        q_dec.delete();
        q_norm.delete();
        q_done.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
    end
    t = 0;
    while (q_done.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("frame_done seen", q_done.size(), 0);
    check("decoded bit count", q_dec.size(), 0);
    check("single acs_init", n_init - init0, 1);
    check("idle after frame", busy_o, 0);
  endtask

  task automatic clear_pm();
    for (int i = 0; i < 128; i++) pm_tab[i] = 12'd100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.sym_valid_i = 1'b0;
    bus.sym_i = 2'd0;
    bus.frame_last_i = 1'b0;
    bus.dec_ready_i = 1'b1;
    pm_min_i = 12'd100;
    clear_pm();
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    pm_tab[2] = 12'd1024;
    pm_tab[3] = 12'd1023;
    pm_tab[4] = 12'd4000;
    send_frame(5, 0, 0);
    clear_pm();
    repeat (3) @(posedge clk);
    #1 send_frame(100, 61, 0);
    repeat (3) @(posedge clk);
    #1 send_frame(40, 0, 30);
    #1 check_reset_outputs("post rst idle");
    send_frame(1, 0, 0);
    pm_tab[1] = 12'd2047;
    repeat (2) @(posedge clk);
    #1 send_frame(3, 0, 0);
    repeat (5) @(negedge clk);
    check("acs queue empty", q_acs.size(), 0);
    check("norm queue empty", q_norm.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
